ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal values are even integers 8..64.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port start_i  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port op_i  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
REQ-006 The block SHALL have ports opdata1_i and opdata2_i  input  WIDTH each  operand A (dividend) and operand B (divisor).
REQ-007 The block SHALL have port hilo_i  input  2*WIDTH  forwarded {HI,LO} accumulator value, sampled with start_i.
REQ-008 The block SHALL have port annul_i  input  1  abort current operation (pipeline flush).
REQ-009 The block SHALL have port busy_o  output  1  stall request to the pipeline.
REQ-010 The block SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port whilo_o  output  1  HI/LO write enable, asserted only with done_o.
REQ-012 The block SHALL have port result_o  output  2*WIDTH  {HI,LO} result.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-014 In IDLE with start_i=1, annul_i=0 and a legal op, operands, op and hilo_i SHALL be captured and busy_o SHALL assert in the next cycle.
REQ-015 MULT/MULTU (and accumulate ops) SHALL spend exactly one cycle in MUL, then DONE: done_o high in cycle 2 after the start cycle (cycle 0).
REQ-016 MULT SHALL treat operands as two's complement; MULTU as unsigned; the product SHALL be the full 2*WIDTH-bit result, HI = upper half.
REQ-017 DIV/DIVU with nonzero divisor SHALL spend exactly WIDTH cycles in DIV (restoring, one quotient bit per cycle), then DONE: done_o in cycle WIDTH+1.
REQ-018 Signed DIV SHALL divide magnitudes, negate the quotient when operand signs differ, give the remainder the dividend's sign; LO = quotient, HI = remainder.
REQ-019 DIV of most-negative by -1 SHALL yield LO = most-negative, HI = 0.
REQ-020 Divide by zero SHALL go directly IDLE->DONE (done_o in cycle 1) with HI = opdata1_i, LO = all ones.
REQ-021 busy_o SHALL be 1 in MUL and DIV, 0 in IDLE and DONE.
REQ-022 DONE SHALL last one cycle, asserting done_o=1 and whilo_o=1, then return to IDLE; start_i in DONE SHALL be ignored.
REQ-023 result_o SHALL update on entry to DONE and hold until the next DONE.
REQ-024 annul_i=1 in any state SHALL force IDLE on the next edge with no done_o/whilo_o pulse; result_o is unchanged.
REQ-025 start_i and annul_i together in IDLE SHALL not start an operation.
REQ-026 start_i while not in IDLE SHALL be ignored and not queued.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, busy_o=0, done_o=0, whilo_o=0, result_o=0, independent of clk, including mid-divide.
REQ-028 After rst deasserts, the first rising edge SHALL be able to accept start_i.

Configuration
REQ-029 Macro EX_MULDIV_MADD_EN SHALL gate the accumulate ops.
REQ-030 With EX_MULDIV_MADD_EN defined, MADD/MADDU SHALL give result_o = hilo_i + product and MSUB/MSUBU result_o = hilo_i - product, modulo 2^(2*WIDTH), signedness of product per op.
REQ-031 Without EX_MULDIV_MADD_EN, op_i[2]=1 SHALL be illegal: start_i ignored, block stays IDLE, no busy_o or done_o.

Verification (WIDTH=32)
REQ-032 MULT A=0xFFFFFFFE (-2), B=3 -> done_o cycle 2, result_o=0xFFFFFFFF_FFFFFFFA; MULTU same operands -> 0x00000002_FFFFFFFA.
REQ-033 DIV A=-7, B=2 -> busy_o 32 cycles, done_o cycle 33, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-034 DIV B=0, A=0x1234 -> done_o cycle 1, result_o=0x00001234_FFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-035 DIVU started, annul_i at cycle 10 -> IDLE cycle 11, no done_o; new MULTU 5*6 accepted, result_o=30.
REQ-036 rst pulled low mid-divide between edges -> all outputs 0 immediately; start_i during busy -> ignored, single done_o.
REQ-037 Macro defined: MADDU hilo_i=0x00000000_FFFFFFFF, A=B=1 -> result_o=0x00000001_00000000; MSUB hilo_i=0, A=1, B=1 -> all ones; macro undefined: MADD start -> no busy_o, no done_o.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage: single-cycle multiply, restoring divide, {HI,LO} result.
// Define EX_MULDIV_MADD_EN to enable the accumulate ops (MADD/MADDU/MSUB/MSUBU); otherwise op_i[2]=1 is rejected.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [2*WIDTH-1:0]   hilo_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 whilo_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 sgn_q, sgn_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  // Decode of the incoming request.
  logic                 op_legal;
  logic                 op_is_div;
  logic                 op_sgn;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;

`ifdef EX_MULDIV_MADD_EN
  logic                 acc_q, acc_d;
  logic                 sub_q, sub_d;
  logic [2*WIDTH-1:0]   hilo_q, hilo_d;
  assign op_legal = 1'b1;
`else
  logic                 unused_hilo;
  assign unused_hilo = ^hilo_i;
  assign op_legal    = ~op_i[2];
`endif

  assign op_is_div = (op_i[2:1] == 2'b01);
  assign op_sgn    = ~op_i[0];
  assign a_neg     = op_sgn & opdata1_i[WIDTH-1];
  assign b_neg     = op_sgn & opdata2_i[WIDTH-1];
  assign a_mag     = a_neg ? ({WIDTH{1'b0}} - opdata1_i) : opdata1_i;
  assign b_mag     = b_neg ? ({WIDTH{1'b0}} - opdata2_i) : opdata2_i;

  // Multiplier: sign/zero-extend to 2*WIDTH so one truncating multiply covers both signednesses.
  logic [2*WIDTH-1:0]   mul_a, mul_b, product, mul_res;

  assign mul_a   = sgn_q ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
  assign mul_b   = sgn_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
  assign product = mul_a * mul_b;

`ifdef EX_MULDIV_MADD_EN
  assign mul_res = !acc_q ? product : (sub_q ? (hilo_q - product) : (hilo_q + product));
`else
  assign mul_res = product;
`endif

  // Restoring divider step on magnitudes; quot_q starts as the dividend and shifts quotient bits in from the right.
  logic [WIDTH:0]       shifted, diff;
  logic                 q_bit;
  logic [WIDTH-1:0]     rem_step, quot_step;
  logic [2*WIDTH-1:0]   div_res;

  assign shifted   = {rem_q, quot_q[WIDTH-1]};
  assign diff      = shifted - {1'b0, opb_q};
  assign q_bit     = ~diff[WIDTH];
  assign rem_step  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_step = {quot_q[WIDTH-2:0], q_bit};
  assign div_res   = {rneg_q ? ({WIDTH{1'b0}} - rem_step)  : rem_step,
                      qneg_q ? ({WIDTH{1'b0}} - quot_step) : quot_step};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sgn_d    = sgn_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
`ifdef EX_MULDIV_MADD_EN
    acc_d    = acc_q;
    sub_d    = sub_q;
    hilo_d   = hilo_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i && op_legal) begin
          opa_d  = opdata1_i;
          opb_d  = op_is_div ? b_mag : opdata2_i;
          sgn_d  = op_sgn;
          quot_d = a_mag;
          rem_d  = '0;
          cnt_d  = '0;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
`ifdef EX_MULDIV_MADD_EN
          acc_d  = op_i[2];
          sub_d  = op_i[1];
          hilo_d = hilo_i;
`endif
          if (!op_is_div) begin
            state_d = MUL;
          end else if (opdata2_i == '0) begin
            state_d  = DONE;
            result_d = {opdata1_i, {WIDTH{1'b1}}};
          end else begin
            state_d = DIV;
          end
        end
      end
      MUL: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          result_d = mul_res;
        end
      end
      DIV: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d  = rem_step;
          quot_d = quot_step;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_d  = DONE;
            result_d = div_res;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sgn_q    <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sgn_q    <= sgn_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

`ifdef EX_MULDIV_MADD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= 1'b0;
      sub_q  <= 1'b0;
      hilo_q <= '0;
    end else begin
      acc_q  <= acc_d;
      sub_q  <= sub_d;
      hilo_q <= hilo_d;
    end
  end
`endif

  assign busy_o   = (state_q == MUL) || (state_q == DIV);
  assign done_o   = (state_q == DONE);
  assign whilo_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv (WIDTH=32): latency, results, annul, reset and start-while-busy behaviour.
module tb_ex_muldiv;
  localparam int W = 32;
  localparam int WIN = 40;
  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010, OP_DIVU = 3'b011;
  localparam logic [2:0] OP_MADD = 3'b100, OP_MADDU = 3'b101, OP_MSUB = 3'b110;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i, annul_i;
  logic [2:0]     op_i;
  logic [W-1:0]   opdata1_i, opdata2_i;
  logic [2*W-1:0] hilo_i, result_o;
  logic           busy_o, done_o, whilo_o;

  int vectors = 0;
  int miscompares = 0;

  int             dc, bc, nd, we;
  logic [2*W-1:0] res, fres;
  logic [63:0]    bt;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hilo_i(hilo_i),
    .annul_i(annul_i), .busy_o(busy_o), .done_o(done_o),
    .whilo_o(whilo_o), .result_o(result_o)
  );

  // Called at a falling edge; that cycle is cycle 0. Observes WIN cycles afterwards.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] h, input int annul_at, input int re1, input int re2,
                        output int done_cyc, output int busy_cnt, output int done_cnt,
                        output int whilo_err, output logic [2*W-1:0] r, output logic [2*W-1:0] r_end,
                        output logic [63:0] busy_trace);
    op_i = op; opdata1_i = a; opdata2_i = b; hilo_i = h;
    start_i = 1'b1; annul_i = 1'b0;
    done_cyc = -1; busy_cnt = 0; done_cnt = 0; whilo_err = 0; r = 'x; busy_trace = '0;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      busy_trace[c] = busy_o;
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; r = result_o; end
      end
      if (whilo_o !== done_o) whilo_err++;
      start_i = (c == re1) || (c == re2);
      annul_i = (c == annul_at);
    end
    r_end = result_o;
    start_i = 1'b0; annul_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
    opdata1_i = '0; opdata2_i = '0; hilo_i = '0;
    #2;
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done_o); end
    vectors++; if (whilo_o !== 1'b0) begin miscompares++; $display("FAIL reset_whilo: got %b want 0", whilo_o); end
    vectors++; if (result_o !== '0) begin miscompares++; $display("FAIL reset_result: got %h want 0", result_o); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mult;
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, '0, -1, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (dc !== 2) begin miscompares++; $display("FAIL mult_done_cycle: got %0d want 2", dc); end
    vectors++; if (bc !== 1) begin miscompares++; $display("FAIL mult_busy_cycles: got %0d want 1", bc); end
    vectors++; if (nd !== 1) begin miscompares++; $display("FAIL mult_done_count: got %0d want 1", nd); end
    vectors++; if (we !== 0) begin miscompares++; $display("FAIL mult_whilo_vs_done: got %0d bad cycles want 0", we); end
    vectors++; if (res !== 64'hFFFF_FFFF_FFFF_FFFA) begin miscompares++; $display("FAIL mult_result: got %h want fffffffffffffffa", res); end
    vectors++; if (fres !== 64'hFFFF_FFFF_FFFF_FFFA) begin miscompares++; $display("FAIL mult_result_hold: got %h want fffffffffffffffa", fres); end
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, '0, -1, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (dc !== 2) begin miscompares++; $display("FAIL multu_done_cycle: got %0d want 2", dc); end
    vectors++; if (res !== 64'h0000_0002_FFFF_FFFA) begin miscompares++; $display("FAIL multu_result: got %h want 00000002fffffffa", res); end
  endtask

  task automatic test_div;
    run_op(OP_DIV, -32'sd7, 32'd2, '0, -1, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (bc !== 32) begin miscompares++; $display("FAIL div_busy_cycles: got %0d want 32", bc); end
    vectors++; if (dc !== 33) begin miscompares++; $display("FAIL div_done_cycle: got %0d want 33", dc); end
    vectors++; if (nd !== 1) begin miscompares++; $display("FAIL div_done_count: got %0d want 1", nd); end
    vectors++; if (we !== 0) begin miscompares++; $display("FAIL div_whilo_vs_done: got %0d bad cycles want 0", we); end
    vectors++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin miscompares++; $display("FAIL div_neg7_by_2: got %h want fffffffffffffffd", res); end
    run_op(OP_DIV, 32'd7, -32'sd2, '0, -1, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (res !== 64'h0000_0001_FFFF_FFFD) begin miscompares++; $display("FAIL div_7_by_neg2: got %h want 00000001fffffffd", res); end
    run_op(OP_DIVU, 32'd100, 32'd7, '0, -1, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (res !== 64'h0000_0002_0000_000E) begin miscompares++; $display("FAIL divu_100_by_7: got %h want 000000020000000e", res); end
    run_op(OP_DIV, 32'h0000_1234, 32'd0, '0, -1, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (dc !== 1) begin miscompares++; $display("FAIL div0_done_cycle: got %0d want 1", dc); end
    vectors++; if (bc !== 0) begin miscompares++; $display("FAIL div0_busy_cycles: got %0d want 0", bc); end
    vectors++; if (res !== 64'h0000_1234_FFFF_FFFF) begin miscompares++; $display("FAIL div0_result: got %h want 00001234ffffffff", res); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, -1, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (dc !== 33) begin miscompares++; $display("FAIL div_minneg_done_cycle: got %0d want 33", dc); end
    vectors++; if (res !== 64'h0000_0000_8000_0000) begin miscompares++; $display("FAIL div_minneg_by_neg1: got %h want 0000000080000000", res); end
  endtask

  task automatic test_annul;
    run_op(OP_DIVU, 32'd100, 32'd7, '0, 10, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (bt[10] !== 1'b1) begin miscompares++; $display("FAIL annul_busy_c10: got %b want 1", bt[10]); end
    vectors++; if (bt[11] !== 1'b0) begin miscompares++; $display("FAIL annul_idle_c11: got %b want 0", bt[11]); end
    vectors++; if (nd !== 0) begin miscompares++; $display("FAIL annul_no_done: got %0d pulses want 0", nd); end
    vectors++; if (fres !== 64'h0000_0000_8000_0000) begin miscompares++; $display("FAIL annul_result_kept: got %h want 0000000080000000", fres); end
    run_op(OP_MULTU, 32'd5, 32'd6, '0, -1, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (dc !== 2) begin miscompares++; $display("FAIL post_annul_done_cycle: got %0d want 2", dc); end
    vectors++; if (res !== 64'd30) begin miscompares++; $display("FAIL post_annul_multu: got %h want 30", res); end
    // Start and annul together in IDLE must not launch anything.
    op_i = OP_MULTU; opdata1_i = 32'd2; opdata2_i = 32'd2; start_i = 1'b1; annul_i = 1'b1;
    nd = 0; bc = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start_i = 1'b0; annul_i = 1'b0;
      if (busy_o) bc++;
      if (done_o) nd++;
    end
    vectors++; if (bc !== 0 || nd !== 0) begin miscompares++; $display("FAIL start_with_annul: got busy=%0d done=%0d want 0/0", bc, nd); end
  endtask

  task automatic test_reset_mid_div;
    op_i = OP_DIVU; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL middiv_busy: got %b want 1", busy_o); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (busy_o !== 1'b0 || done_o !== 1'b0 || whilo_o !== 1'b0) begin
      miscompares++; $display("FAIL middiv_reset_flags: got busy=%b done=%b whilo=%b want 0/0/0", busy_o, done_o, whilo_o);
    end
    vectors++; if (result_o !== '0) begin miscompares++; $display("FAIL middiv_reset_result: got %h want 0", result_o); end
    @(negedge clk);
    rst = 1'b1;
    run_op(OP_MULTU, 32'd7, 32'd9, '0, -1, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (dc !== 2) begin miscompares++; $display("FAIL post_reset_done_cycle: got %0d want 2", dc); end
    vectors++; if (res !== 64'd63) begin miscompares++; $display("FAIL post_reset_multu: got %h want 63", res); end
  endtask

  task automatic test_back_to_back;
    // start_i re-asserted during DIV (cycle 5) and during DONE (cycle 33) must be dropped.
    run_op(OP_DIVU, 32'd100, 32'd7, '0, -1, 5, 33, dc, bc, nd, we, res, fres, bt);
    vectors++; if (nd !== 1) begin miscompares++; $display("FAIL busy_start_done_count: got %0d want 1", nd); end
    vectors++; if (dc !== 33) begin miscompares++; $display("FAIL busy_start_done_cycle: got %0d want 33", dc); end
    vectors++; if (bc !== 32) begin miscompares++; $display("FAIL busy_start_busy_cycles: got %0d want 32", bc); end
    vectors++; if (res !== 64'h0000_0002_0000_000E) begin miscompares++; $display("FAIL busy_start_result: got %h want 000000020000000e", res); end
  endtask

  task automatic test_madd;
`ifdef EX_MULDIV_MADD_EN
    run_op(OP_MADDU, 32'd1, 32'd1, 64'h0000_0000_FFFF_FFFF, -1, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (dc !== 2) begin miscompares++; $display("FAIL maddu_done_cycle: got %0d want 2", dc); end
    vectors++; if (res !== 64'h0000_0001_0000_0000) begin miscompares++; $display("FAIL maddu_result: got %h want 0000000100000000", res); end
    run_op(OP_MSUB, 32'd1, 32'd1, '0, -1, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL msub_result: got %h want ffffffffffffffff", res); end
`else
    run_op(OP_MADD, 32'd2, 32'd3, 64'd5, -1, -1, -1, dc, bc, nd, we, res, fres, bt);
    vectors++; if (bc !== 0) begin miscompares++; $display("FAIL madd_disabled_busy: got %0d want 0", bc); end
    vectors++; if (nd !== 0) begin miscompares++; $display("FAIL madd_disabled_done: got %0d want 0", nd); end
    vectors++; if (fres !== 64'h0000_0002_0000_000E) begin miscompares++; $display("FAIL madd_disabled_result: got %h want 000000020000000e", fres); end
`endif
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_annul;
    test_reset_mid_div;
    test_back_to_back;
    test_madd;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
